wt_mem_sched: RTL and testbench

WT_MEM_SCHED -- requirements
Module: wt_mem_sched

---
 rtl/wt_mem_pkg.sv | 13 +
 rtl/wt_pair_fifo.sv | 78 +++++++
 rtl/wt_mem_sched.sv | 175 +++++++++++++++++
 tb/tb_wt_mem_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_mem_pkg.sv
// Shared types and constants for the weight-memory burst scheduler.
package wt_mem_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/wt_pair_fifo.sv
// Two-entry FIFO of ROM word pairs; entry 0 is the registered head seen downstream.
module wt_pair_fifo
  import wt_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 144
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_a,
  input  logic [DATA_WIDTH-1:0] push_b,
  input  logic                  push_bv,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_a,
  output logic [DATA_WIDTH-1:0] head_b,
  output logic                  head_bv,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] tail_a, tail_b;
  logic                  tail_bv;
  logic [DATA_WIDTH-1:0] head_a_n, head_b_n, tail_a_n, tail_b_n;
  logic                  head_bv_n, tail_bv_n;
  logic [OCC_W-1:0]      occ_n;

  // Pop shifts the tail forward, then a push fills the first free slot.
  always_comb begin
    head_a_n  = head_a;
    head_b_n  = head_b;
    head_bv_n = head_bv;
    tail_a_n  = tail_a;
    tail_b_n  = tail_b;
    tail_bv_n = tail_bv;
    occ_n     = occ;
    if (pop && occ != '0) begin
      head_a_n  = tail_a;
      head_b_n  = tail_b;
      head_bv_n = tail_bv;
      occ_n     = occ - OCC_W'(1);
    end
    if (push && occ_n != OCC_W'(FIFO_DEPTH)) begin
      if (occ_n == '0) begin
        head_a_n  = push_a;
        head_b_n  = push_b;
        head_bv_n = push_bv;
      end else begin
        tail_a_n  = push_a;
        tail_b_n  = push_b;
        tail_bv_n = push_bv;
      end
      occ_n = occ_n + OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_a     <= '0;
      head_b     <= '0;
      head_bv    <= 1'b0;
      tail_a     <= '0;
      tail_b     <= '0;
      tail_bv    <= 1'b0;
      occ        <= '0;
      head_valid <= 1'b0;
    end else begin
      head_a     <= head_a_n;
      head_b     <= head_b_n;
      head_bv    <= head_bv_n;
      tail_a     <= tail_a_n;
      tail_b     <= tail_b_n;
      tail_bv    <= tail_bv_n;
      occ        <= occ_n;
      head_valid <= (occ_n != '0);
    end
  end

endmodule

// File: rtl/wt_mem_sched.sv
// Burst scheduler fetching word pairs from a dual-port weight ROM into a 2-deep FIFO.
// Optional WT_MEM_SCHED_STALL_CNT_EN adds a saturating downstream stall counter.
module wt_mem_sched
  import wt_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned DEPTH      = 76
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rom_addr_a,
  output logic [ADDR_WIDTH-1:0] rom_addr_b,
  input  logic [DATA_WIDTH-1:0] rom_q_a,
  input  logic [DATA_WIDTH-1:0] rom_q_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
`ifdef WT_MEM_SCHED_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  out_b_valid
);

  localparam int unsigned SUM_W  = ADDR_WIDTH + 1;
  localparam int unsigned FILL_W = OCC_W + 1;

  // Modular increment at DEPTH, not at 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(inc);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return s[ADDR_WIDTH-1:0];
  endfunction

  sched_state_e          state, state_n;
  logic [ADDR_WIDTH-1:0] next_a, next_a_n;
  logic [ADDR_WIDTH-1:0] beats_left, beats_left_n;
  logic [ADDR_WIDTH-1:0] beats_total;
  logic [ADDR_WIDTH-1:0] addr_a_n, addr_b_n;
  logic                  odd, odd_n;
  logic                  inflight, inflight_bv;
  logic                  issue, issue_bv;
  logic                  accept, reject, pop, room;
  logic                  busy_n, done_n, err_n;
  logic [OCC_W-1:0]      occ, occ_after;

  always_comb begin
    pop         = out_valid & out_ready;
    occ_after   = occ - OCC_W'(pop);
    // Free slots account for this cycle's pop so back-to-back beats keep flowing.
    room        = (FILL_W'(occ_after) + FILL_W'(inflight)) < FILL_W'(FIFO_DEPTH);
    accept      = start && (state == ST_IDLE) && (32'(base) < DEPTH);
    reject      = start && (state == ST_IDLE) && !(32'(base) < DEPTH);
    beats_total = ADDR_WIDTH'((SUM_W'(count) + SUM_W'(1)) >> 1);
  end

  // Next-state, address generation and pulse outputs.
  always_comb begin
    state_n      = state;
    next_a_n     = next_a;
    beats_left_n = beats_left;
    odd_n        = odd;
    addr_a_n     = rom_addr_a;
    addr_b_n     = rom_addr_b;
    issue        = 1'b0;
    issue_bv     = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reject) begin
          err_n = 1'b1;
        end else if (accept) begin
          if (count == '0) begin
            done_n = 1'b1;
          end else begin
            issue        = 1'b1;
            issue_bv     = !(count[0] && beats_total == ADDR_WIDTH'(1));
            addr_a_n     = base;
            addr_b_n     = wrap_inc(base, 2'd1);
            next_a_n     = wrap_inc(base, 2'd2);
            beats_left_n = beats_total - ADDR_WIDTH'(1);
            odd_n        = count[0];
            state_n      = (beats_total == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (room) begin
          issue        = 1'b1;
          issue_bv     = !(odd && beats_left == ADDR_WIDTH'(1));
          addr_a_n     = next_a;
          addr_b_n     = wrap_inc(next_a, 2'd1);
          next_a_n     = wrap_inc(next_a, 2'd2);
          beats_left_n = beats_left - ADDR_WIDTH'(1);
          if (beats_left == ADDR_WIDTH'(1)) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight && occ_after == '0) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      next_a      <= '0;
      beats_left  <= '0;
      odd         <= 1'b0;
      inflight    <= 1'b0;
      inflight_bv <= 1'b0;
      rom_addr_a  <= '0;
      rom_addr_b  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      next_a      <= next_a_n;
      beats_left  <= beats_left_n;
      odd         <= odd_n;
      inflight    <= issue;
      inflight_bv <= issue_bv;
      rom_addr_a  <= addr_a_n;
      rom_addr_b  <= addr_b_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

  // ROM data settles during the issue cycle and is captured on the following edge.
  wt_pair_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_a    (rom_q_a),
    .push_b    (rom_q_b),
    .push_bv   (inflight_bv),
    .pop       (pop),
    .head_valid(out_valid),
    .head_a    (out_a),
    .head_b    (out_b),
    .head_bv   (out_b_valid),
    .occ       (occ)
  );

`ifdef WT_MEM_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (busy && out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wt_mem_sched.sv
// Directed plus randomized bench for wt_mem_sched against an arithmetic burst model.
module tb_wt_mem_sched;

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 144;
  localparam int unsigned DEPTH = 76;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] count = '0;
  logic          busy, done, err, out_valid, out_b_valid;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [DW-1:0] rom_q_a, rom_q_b, out_a, out_b;
`ifdef WT_MEM_SCHED_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  logic [DW-1:0] rom [DEPTH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_q_a = (rom_addr_a < AW'(DEPTH)) ? rom[rom_addr_a] : '0;
  assign rom_q_b = (rom_addr_b < AW'(DEPTH)) ? rom[rom_addr_b] : '0;

  wt_mem_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_q_a    (rom_q_a),
    .rom_q_b    (rom_q_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
`ifdef WT_MEM_SCHED_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .out_b_valid(out_b_valid)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_busy"}, 32'(busy), 0);
    chk1({tag, "_done"}, 32'(done), 0);
    chk1({tag, "_err"}, 32'(err), 0);
    chk1({tag, "_valid"}, 32'(out_valid), 0);
    chk1({tag, "_bvalid"}, 32'(out_b_valid), 0);
    chk1({tag, "_addr_a"}, 32'(rom_addr_a), 0);
    chk1({tag, "_addr_b"}, 32'(rom_addr_b), 0);
    chk({tag, "_out_a"}, out_a, '0);
    chk({tag, "_out_b"}, out_b, '0);
`ifdef WT_MEM_SCHED_STALL_CNT_EN
    chk1({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
`endif
  endtask

  // One burst: the model is the list of beats k with words (b+2k) and (b+2k+1) mod DEPTH.
  task automatic run_burst(input int b, input int c, input int rmode, input int stall_at,
                           input bit pre, input bit chain, input int nb, input int nc,
                           input int poke_at, input int pb);
    int nbeats, k, cyc, proto, stalls, stall_left;
    bit finished, stall_used, seen_valid, ebv;
    nbeats = (c + 1) / 2;
    k = 0; cyc = 0; proto = 0; stalls = 0; stall_left = 0;
    finished = 0; stall_used = 0; seen_valid = 0;
    if (!pre) begin
      base = AW'(b);
      count = AW'(c);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    if (nbeats == 0) begin
      chk1("zero_done", 32'(done), 1);
      chk1("zero_busy", 32'(busy), 0);
      @(negedge clk);
      chk1("zero_done_pulse", 32'(done), 0);
      chk1("zero_valid", 32'(out_valid), 0);
`ifdef WT_MEM_SCHED_STALL_CNT_EN
      chk1("zero_stall_cnt", 32'(stall_cnt), 0);
`endif
      return;
    end
    chk1("first_addr_a", 32'(rom_addr_a), 32'(b % DEPTH));
    if (c > 1) chk1("first_addr_b", 32'(rom_addr_b), 32'((b + 1) % DEPTH));
    while (!finished && cyc < 500) begin
      if (k == nbeats) begin
        chk1("done", 32'(done), 1);
        chk1("busy_end", 32'(busy), 0);
        chk1("valid_end", 32'(out_valid), 0);
`ifdef WT_MEM_SCHED_STALL_CNT_EN
        chk1("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
        finished = 1;
        if (chain) begin
          base = AW'(nb);
          count = AW'(nc);
          start = 1'b1;
        end
      end else begin
        if (done !== 1'b0) proto++;
        if (busy !== 1'b1) proto++;
        if (poke_at >= 0 && cyc == poke_at + 1) chk1("poke_no_err", 32'(err), 0);
        start = (cyc == poke_at);
        if (start) begin
          base = AW'(pb);
          count = AW'(3);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else if (stall_at >= 0 && k == stall_at && out_valid && !stall_used) begin
          out_ready = 1'b0;
          stall_left = 4;
          stall_used = 1;
        end else begin
          out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        end
        if (out_valid === 1'b1) begin
          if (!seen_valid) chk1("latency", 32'(cyc), 2);
          seen_valid = 1;
          ebv = !((c % 2 == 1) && (k == nbeats - 1));
          chk($sformatf("beat%0d_a", k), out_a, rom[(b + 2 * k) % DEPTH]);
          chk1($sformatf("beat%0d_bv", k), 32'(out_b_valid), 32'(ebv));
          if (ebv) chk($sformatf("beat%0d_b", k), out_b, rom[(b + 2 * k + 1) % DEPTH]);
          if (out_ready) k++;
          else stalls++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk1("finished", 32'(finished), 1);
    chk1("protocol", 32'(proto), 0);
    if (stall_at >= 0) chk1("stall_cycles", 32'(stalls), 5);
  endtask

  initial begin
    int w;
    for (int i = 0; i < int'(DEPTH); i++)
      rom[i] = {$urandom, $urandom, $urandom, $urandom, 16'(i)};

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed bursts: plain, ROM wrap, odd count, mid-burst stall
    run_burst(0, 4, 0, -1, 0, 0, 0, 0, -1, 0);
    run_burst(74, 4, 0, -1, 0, 0, 0, 0, -1, 0);
    run_burst(10, 3, 0, -1, 0, 0, 0, 0, -1, 0);
    run_burst(20, 8, 0, 1, 0, 0, 0, 0, -1, 0);

    // Out-of-range base
    base = AW'(76); count = AW'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("err_pulse", 32'(err), 1);
    chk1("err_busy", 32'(busy), 0);
    @(negedge clk);
    chk1("err_clear", 32'(err), 0);
    chk1("err_busy2", 32'(busy), 0);
    chk1("err_no_done", 32'(done), 0);

    // Starts while busy must be ignored
    run_burst(30, 10, 0, -1, 0, 0, 0, 0, 3, 90);
    run_burst(40, 10, 1, -1, 0, 0, 0, 0, 4, 5);

    // count==0, single odd beat at the top of the ROM, back-to-back via done
    run_burst(5, 0, 0, -1, 0, 0, 0, 0, -1, 0);
    run_burst(75, 1, 0, -1, 0, 0, 0, 0, -1, 0);
    run_burst(3, 6, 0, -1, 0, 1, 50, 5, -1, 0);
    run_burst(50, 5, 1, -1, 1, 0, 0, 0, -1, 0);

    // Reset after the first of four beats
    base = AW'(0); count = AW'(8); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk1("rst_burst_began", 32'(out_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) w++;
    end
    chk1("post_rst_quiet", 32'(w), 0);
    run_burst(0, 2, 0, -1, 0, 0, 0, 0, -1, 0);

    // Randomized bursts and rejected starts
    for (int n = 0; n < 20; n++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 30)),
                1, -1, 0, 0, 0, 0, -1, 0);
      if (n % 5 == 4) begin
        base = AW'($urandom_range(DEPTH, 127)); count = AW'($urandom_range(1, 9)); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("rand_err", 32'(err), 1);
        chk1("rand_err_busy", 32'(busy), 0);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
